// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, sizes, entry state and the
// x10 accumulate helper used by the digit path.
package keypad_pkg;
    localparam int         PW_WIDTH   = 14;
    localparam int         MAX_DIGITS = 4;
    localparam int         CNT_W      = 3;
    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;

    typedef enum logic {IDLE = 1'b0, ENTRY = 1'b1} state_t;

    // acc*10 + d as shifts and adds; acc <= 999 on entry so 14 bits suffice
    function automatic logic [PW_WIDTH-1:0] acc_push(input logic [PW_WIDTH-1:0] acc,
                                                     input logic [3:0] d);
        return (acc << 3) + (acc << 1) + {{(PW_WIDTH-4){1'b0}}, d};
    endfunction
endpackage

// File: rtl/keypad_entry_if.sv
// Keypad-side inputs and door-controller-side results of keypad_entry.
// master: keypad scanner / consumer side; slave: keypad_entry itself.
interface keypad_entry_if;
    import keypad_pkg::*;
    logic                key_press;
    logic [3:0]          key_code;
    logic [PW_WIDTH-1:0] password_out;
    logic                entry_valid;
    logic                entry_error;
    logic [CNT_W-1:0]    digit_count;
    logic                timeout_pulse;

    modport master (output key_press, key_code,
                    input  password_out, entry_valid, entry_error, digit_count, timeout_pulse);
    modport slave  (input  key_press, key_code,
                    output password_out, entry_valid, entry_error, digit_count, timeout_pulse);
endinterface

// File: rtl/key_debouncer.sv
// 2-flop synchronizer followed by a stability counter. The debounced level
// only flips after DEBOUNCE_CYCLES consecutive samples disagree with it;
// press is high during the cycle in which a 0->1 flip is decided.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip  = (s2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign press = flip & s2;

    // metastability synchronizer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // count consecutive disagreeing samples; any agreeing sample restarts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s2 == level) begin
            cnt   <= '0;
        end else if (flip) begin
            cnt   <= '0;
            level <= s2;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: debounced key events build a 4-digit decimal value,
// ENTER commits it to password_out. Optional inactivity timeout is
// compiled in with KEYPAD_TIMEOUT_EN; without it timeout_pulse stays 0.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic           clk,
    input  logic           reset,
    keypad_entry_if.slave  kp
);
    state_t              state, state_nxt;
    logic [PW_WIDTH-1:0] acc, acc_nxt, pw, pw_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                valid_q, valid_nxt, err_q, err_nxt, tmo_q, tmo_nxt;
    logic                deb_level, deb_press, key_evt, tmo_hit;
    logic                is_digit, is_clear, is_enter;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk   (clk),
        .reset (reset),
        .raw   (kp.key_press),
        .level (deb_level),
        .press (deb_press)
    );

    // an event is only a release->press transition of the debounced level
    assign key_evt  = deb_press & ~deb_level;
    assign is_digit = (kp.key_code <= 4'd9);
    assign is_clear = (kp.key_code == KEY_CLEAR);
    assign is_enter = (kp.key_code == KEY_ENTER);

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tcnt;

    // a key event in the expiry cycle takes priority over the timeout
    assign tmo_hit = (state == ENTRY) && !key_evt && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // idle counter: runs only in ENTRY, restarts on any key event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tcnt <= '0;
        else if (key_evt || state == IDLE || tmo_hit)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // state, accumulator and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            pw      <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            pw      <= pw_nxt;
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
            tmo_q   <= tmo_nxt;
        end
    end

    // next state and accumulator update from the decoded key event
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        if (key_evt) begin
            if (is_digit && cnt < CNT_W'(MAX_DIGITS)) begin
                acc_nxt   = acc_push(acc, kp.key_code);
                cnt_nxt   = cnt + 1'b1;
                state_nxt = ENTRY;
            end else if (is_clear || (is_enter && state == ENTRY)) begin
                acc_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        end else if (tmo_hit) begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end
    end

    // commit / error / timeout pulses and the committed password
    always_comb begin
        valid_nxt = key_evt && is_enter && (state == ENTRY);
        err_nxt   = key_evt && is_enter && (state == IDLE);
        tmo_nxt   = tmo_hit;
        pw_nxt    = valid_nxt ? acc : pw;
    end

    assign kp.password_out  = pw;
    assign kp.entry_valid   = valid_q;
    assign kp.entry_error   = err_q;
    assign kp.digit_count   = cnt;
    assign kp.timeout_pulse = tmo_q;
endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed cases plus random key
// sequences compared against a decimal-arithmetic model of the keypad.
module tb_keypad_entry;
    localparam int DEB = 4;
    localparam int TO  = 20;

    logic clk = 1'b0;
    logic reset;
    int   errs = 0, checks = 0, cyc = 0;
    int   nv = 0, ne = 0, nt = 0;             // observed pulse-cycle counts
    int   e_nv = 0, e_ne = 0, e_nt = 0;       // expected pulse counts
    int   m_val = 0, m_cnt = 0, m_pw = 0;     // reference model
    int   c0, c1, lat;
    bit   ok;

    keypad_entry_if kp();

    keypad_entry #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // count every cycle each pulse is high, so a stretched pulse is caught
    always @(negedge clk) begin
        if (kp.entry_valid)   nv <= nv + 1;
        if (kp.entry_error)   ne <= ne + 1;
        if (kp.timeout_pulse) nt <= nt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_key(input int code);
        if (code <= 9) begin
            if (m_cnt < 4) begin
                m_val = m_val * 10 + code;
                m_cnt++;
            end
        end else if (code == 10) begin
            m_val = 0;
            m_cnt = 0;
        end else if (code == 11) begin
            if (m_cnt > 0) begin
                m_pw = m_val;
                e_nv++;
                m_val = 0;
                m_cnt = 0;
            end else begin
                e_ne++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, int'(kp.digit_count), m_cnt);
        chk({tag, ".pw"},    int'(kp.password_out), m_pw);
        chk({tag, ".nv"},    nv, e_nv);
        chk({tag, ".ne"},    ne, e_ne);
        chk({tag, ".nt"},    nt, e_nt);
    endtask

    // clean press: hold well past debounce, release well past debounce
    task automatic press(input int code);
        kp.key_code  = 4'(code);
        kp.key_press = 1'b1;
        tick(DEB + 4);
        kp.key_press = 1'b0;
        tick(DEB + 4);
        model_key(code);
    endtask

    // bouncy press: short high/low runs below the debounce length, then held
    task automatic bounce_press(input int code);
        kp.key_code = 4'(code);
        repeat (3) begin
            kp.key_press = 1'b1;
            tick($urandom_range(1, DEB - 1));
            kp.key_press = 1'b0;
            tick($urandom_range(1, DEB - 1));
        end
        press(code);
    endtask

    task automatic wait_count(input int val, input int lim, output bit found);
        found = 1'b0;
        for (int i = 0; i < lim && !found; i++) begin
            tick(1);
            if (int'(kp.digit_count) == val) found = 1'b1;
        end
    endtask

    initial begin
        reset        = 1'b0;
        kp.key_press = 1'b0;
        kp.key_code  = 4'h0;
        tick(3);
        chk("rst.pw",    int'(kp.password_out), 0);
        chk("rst.count", int'(kp.digit_count), 0);
        chk("rst.valid", int'(kp.entry_valid), 0);
        chk("rst.error", int'(kp.entry_error), 0);
        chk("rst.tmo",   int'(kp.timeout_pulse), 0);
        reset = 1'b1;
        tick(2);

        // 1111
        press(1); press(1); press(1);
        press(1); check_all("four_ones");
        press(11); check_all("enter1111");
        chk("pw_1111", int'(kp.password_out), 1111);

        // bounced 5 gives exactly one digit
        bounce_press(5); check_all("bounce5");
        press(11); check_all("enter5");
        chk("pw_5", int'(kp.password_out), 5);

        // fifth digit ignored
        press(9); press(8); press(7); press(6); press(5); check_all("fifth");
        press(11);
        chk("pw_9876", int'(kp.password_out), 9876);

        // clear then enter is an error, password held
        press(3); press(4); press(10); check_all("clear");
        press(11); check_all("enter_empty");
        chk("pw_hold", int'(kp.password_out), 9876);

        // ignored codes and leading zeros
        press(13); press(0); press(15); press(0); press(4); press(2); check_all("zeros");
        press(11);
        chk("pw_42", int'(kp.password_out), 42);

        // asynchronous reset mid-entry
        press(1); press(2); check_all("pre_rst");
        #2 reset = 1'b0;
        #1;
        chk("arst.pw",    int'(kp.password_out), 0);
        chk("arst.count", int'(kp.digit_count), 0);
        chk("arst.valid", int'(kp.entry_valid), 0);
        m_pw = 0; m_val = 0; m_cnt = 0;
        tick(2);
        reset = 1'b1;
        tick(2);
        press(4); press(11); check_all("post_rst");
        chk("pw_4", int'(kp.password_out), 4);

`ifdef KEYPAD_TIMEOUT_EN
        // "7" then idle: cleared after the expiry cycle, pulse one cycle
        c0 = cyc;
        kp.key_code  = 4'd7;
        kp.key_press = 1'b1;
        wait_count(1, 30, ok);
        chk("tmo.evt_seen", int'(ok), 1);
        c1  = cyc;
        lat = c1 - c0;
        chk("tmo.latency_ok", int'(lat >= DEB + 2 && lat <= DEB + 3), 1);
        tick(1);
        kp.key_press = 1'b0;
        while (cyc < c1 + TO - 1) tick(1);
        chk("tmo.before_cnt", int'(kp.digit_count), 1);
        chk("tmo.before_p",   int'(kp.timeout_pulse), 0);
        tick(1);
        chk("tmo.after_cnt", int'(kp.digit_count), 0);
        chk("tmo.after_p",   int'(kp.timeout_pulse), 1);
        tick(2);
        e_nt++;
        check_all("tmo");

        // a key whose event lands exactly on the expiry cycle wins
        kp.key_code  = 4'd7;
        kp.key_press = 1'b1;
        wait_count(1, 30, ok);
        chk("race.evt_seen", int'(ok), 1);
        c1 = cyc;
        tick(1);
        kp.key_press = 1'b0;
        while (cyc < c1 + TO - lat) tick(1);
        kp.key_code  = 4'd3;
        kp.key_press = 1'b1;
        while (cyc < c1 + TO) tick(1);
        chk("race.count", int'(kp.digit_count), 2);
        chk("race.p",     int'(kp.timeout_pulse), 0);
        tick(2);
        kp.key_press = 1'b0;
        model_key(7); model_key(3);
        check_all("race");
        tick(DEB + 4);
        press(11);
        chk("pw_73", int'(kp.password_out), 73);
`else
        // without the timeout a partial entry persists
        press(7);
        tick(3 * TO);
        check_all("no_tmo");
        press(10);
`endif

        // random key sequences against the model
        for (int k = 0; k < 80; k++) begin
            int r, code;
            r    = $urandom_range(0, 19);
            code = (r >= 16) ? 11 : r;
            if (m_cnt == 0 && ($urandom_range(0, 3) == 0)) bounce_press(code);
            else                                           press(code);
            check_all($sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // hard stop if the run ever wedges
    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end
endmodule
